// File: rtl/fifo_pkg.sv
// Shared defaults for the synchronous FIFO and its interface bundle.
package fifo_pkg;
  localparam int FIFO_DATA_W       = 8;
  localparam int FIFO_DEPTH        = 16;
  localparam int FIFO_ALM_FULL_TH  = 14;
  localparam int FIFO_ALM_EMPTY_TH = 2;
  localparam int FIFO_PTR_W        = $clog2(FIFO_DEPTH);
  localparam int FIFO_CNT_W        = FIFO_PTR_W + 1;
endpackage

// File: rtl/fifo_intf.sv
// Signal bundle between producer/consumer and the FIFO.
// With FIFO_ERR_EN defined the bundle also carries the sticky error flags.
interface fifo_intf
  import fifo_pkg::*;
#(
  parameter int DATA_W = FIFO_DATA_W
) (
  input logic clk
);
  logic              wren;
  logic [DATA_W-1:0] wrdata;
  logic              rden;
  logic [DATA_W-1:0] rddata;
  logic              full;
  logic              empty;
  logic              alm_full;
  logic              alm_empty;
`ifdef FIFO_ERR_EN
  logic              overflow;
  logic              underflow;
`endif

  modport driver (
    input  clk,
    output wren, wrdata, rden
  );

  modport monitor (
`ifdef FIFO_ERR_EN
    input overflow, underflow,
`endif
    input clk, rddata, full, empty, alm_full, alm_empty
  );
endinterface

// File: rtl/fifo_mem.sv
// Simple dual-port register array: synchronous write, registered read.
// Only the read register is reset; storage contents are left as-is.
module fifo_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  // Store the incoming word on an accepted write.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Load the read register on an accepted read; hold otherwise.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)   rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/modport_fifo.sv
// Single-clock synchronous FIFO with full/empty and almost-full/almost-empty
// flags. Optional macro FIFO_ERR_EN adds sticky o_overflow/o_underflow.
module modport_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_W       = FIFO_DATA_W,
  parameter int DEPTH        = FIFO_DEPTH,
  parameter int ALM_FULL_TH  = FIFO_ALM_FULL_TH,
  parameter int ALM_EMPTY_TH = FIFO_ALM_EMPTY_TH
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_wren,
  input  logic [DATA_W-1:0] i_wrdata,
  input  logic              i_rden,
  output logic [DATA_W-1:0] o_rddata,
`ifdef FIFO_ERR_EN
  output logic              o_overflow,
  output logic              o_underflow,
`endif
  output logic              o_full,
  output logic              o_empty,
  output logic              o_alm_full,
  output logic              o_alm_empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             wr_acc;
  logic             rd_acc;

  // Acceptance is judged on the flags seen before the edge.
  always_comb begin
    wr_acc = i_wren && !o_full;
    rd_acc = i_rden && !o_empty;
  end

  // Pointers wrap naturally; count tells full from empty when they match.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      if (wr_acc && !rd_acc)      count <= count + 1'b1;
      else if (rd_acc && !wr_acc) count <= count - 1'b1;
    end
  end

  // Status flags decode the registered occupancy.
  always_comb begin
    o_full      = (count == CNT_W'(DEPTH));
    o_empty     = (count == '0);
    o_alm_full  = (count >= CNT_W'(ALM_FULL_TH));
    o_alm_empty = (count <= CNT_W'(ALM_EMPTY_TH));
  end

`ifdef FIFO_ERR_EN
  // Sticky error capture: cleared only by reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      if (i_wren && o_full)  o_overflow  <= 1'b1;
      if (i_rden && o_empty) o_underflow <= 1'b1;
    end
  end
`endif

  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (PTR_W)
  ) u_mem (
    .clk   (clk),
    .rstn  (rstn),
    .we    (wr_acc),
    .waddr (wr_ptr),
    .wdata (i_wrdata),
    .re    (rd_acc),
    .raddr (rd_ptr),
    .rdata (o_rddata)
  );
endmodule

// File: tb/tb_modport_fifo.sv
// Directed bench for modport_fifo (DATA_W=8, DEPTH=16, AF=14, AE=2).
module tb_modport_fifo;
  logic clk;
  logic rstn;
  int   errors;
  int   checks;

  fifo_intf #(.DATA_W(8)) bus (.clk(clk));

  modport_fifo dut (
    .clk         (clk),
    .rstn        (rstn),
    .i_wren      (bus.wren),
    .i_wrdata    (bus.wrdata),
    .i_rden      (bus.rden),
    .o_rddata    (bus.rddata),
`ifdef FIFO_ERR_EN
    .o_overflow  (bus.overflow),
    .o_underflow (bus.underflow),
`endif
    .o_full      (bus.full),
    .o_empty     (bus.empty),
    .o_alm_full  (bus.alm_full),
    .o_alm_empty (bus.alm_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {full, alm_full, empty, alm_empty} for a given occupancy.
  function automatic logic [3:0] exp_flags(input int c);
    return {c == 16, c >= 14, c == 0, c <= 2};
  endfunction

  function automatic logic [3:0] flags();
    return {bus.full, bus.alm_full, bus.empty, bus.alm_empty};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] d);
    bus.wren = 1'b1; bus.wrdata = d;
    tick();
    bus.wren = 1'b0;
  endtask

  task automatic rd();
    bus.rden = 1'b1;
    tick();
    bus.rden = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    bus.wren = 1'b0; bus.rden = 1'b0; bus.wrdata = 8'h00;
    tick(); tick();
    checks++;
    if (flags() !== exp_flags(0)) begin
      errors++; $display("FAIL reset_flags: got %b want %b", flags(), exp_flags(0));
    end
    checks++;
    if (bus.rddata !== 8'h00) begin
      errors++; $display("FAIL reset_rddata: got %h want 00", bus.rddata);
    end
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_fill_drain();
    for (int i = 1; i <= 16; i++) begin
      wr(8'(i));
      checks++;
      if (flags() !== exp_flags(i)) begin
        errors++; $display("FAIL fill_flags[%0d]: got %b want %b", i, flags(), exp_flags(i));
      end
    end
    wr(8'hFF);
    checks++;
    if (flags() !== exp_flags(16)) begin
      errors++; $display("FAIL overfill_flags: got %b want %b", flags(), exp_flags(16));
    end
    for (int i = 1; i <= 16; i++) begin
      rd();
      checks++;
      if (bus.rddata !== 8'(i)) begin
        errors++; $display("FAIL drain_data[%0d]: got %h want %h", i, bus.rddata, 8'(i));
      end
      checks++;
      if (flags() !== exp_flags(16 - i)) begin
        errors++; $display("FAIL drain_flags[%0d]: got %b want %b", i, flags(), exp_flags(16 - i));
      end
    end
    rd();
    checks++;
    if (bus.rddata !== 8'h10) begin
      errors++; $display("FAIL empty_read_hold: got %h want 10", bus.rddata);
    end
  endtask

  task automatic test_reset_mid();
    wr(8'h11); wr(8'h12); wr(8'h13);
    bus.rden = 1'b1; bus.wren = 1'b1; bus.wrdata = 8'h14;
    tick();
    bus.rden = 1'b0; bus.wren = 1'b0;
    rstn = 1'b0;
    #1;
    checks++;
    if (flags() !== exp_flags(0)) begin
      errors++; $display("FAIL midreset_flags: got %b want %b", flags(), exp_flags(0));
    end
    checks++;
    if (bus.rddata !== 8'h00) begin
      errors++; $display("FAIL midreset_rddata: got %h want 00", bus.rddata);
    end
    #1 rstn = 1'b1;
    tick();
    rd();
    checks++;
    if (bus.rddata !== 8'h00 || bus.empty !== 1'b1) begin
      errors++; $display("FAIL postreset_read: got %h/%b want 00/1", bus.rddata, bus.empty);
    end
    wr(8'h77);
    rd();
    checks++;
    if (bus.rddata !== 8'h77 || bus.empty !== 1'b1) begin
      errors++; $display("FAIL postreset_data: got %h/%b want 77/1", bus.rddata, bus.empty);
    end
  endtask

  task automatic test_alm_empty();
    for (int i = 1; i <= 3; i++) begin
      wr(8'(8'h40 + i));
      checks++;
      if (bus.alm_empty !== (i <= 2)) begin
        errors++; $display("FAIL alm_empty_fill[%0d]: got %b want %b", i, bus.alm_empty, (i <= 2));
      end
    end
    rd();
    checks++;
    if (bus.alm_empty !== 1'b1 || bus.rddata !== 8'h41) begin
      errors++; $display("FAIL alm_empty_read: got %b/%h want 1/41", bus.alm_empty, bus.rddata);
    end
    rd(); rd();
    checks++;
    if (flags() !== exp_flags(0) || bus.rddata !== 8'h43) begin
      errors++; $display("FAIL alm_empty_drain: got %b/%h want %b/43", flags(), bus.rddata, exp_flags(0));
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 5; i++) wr(8'(8'h20 + i));
    bus.wren = 1'b1; bus.rden = 1'b1;
    for (int k = 0; k < 40; k++) begin
      bus.wrdata = 8'(8'h25 + k);
      tick();
      checks++;
      if (bus.rddata !== 8'(8'h20 + k) || flags() !== exp_flags(5)) begin
        errors++;
        $display("FAIL b2b[%0d]: got %h/%b want %h/%b", k, bus.rddata, flags(), 8'(8'h20 + k), exp_flags(5));
      end
    end
    bus.wren = 1'b0; bus.rden = 1'b0;
    for (int k = 40; k < 45; k++) begin
      rd();
      checks++;
      if (bus.rddata !== 8'(8'h20 + k)) begin
        errors++; $display("FAIL b2b_drain[%0d]: got %h want %h", k, bus.rddata, 8'(8'h20 + k));
      end
    end
    checks++;
    if (flags() !== exp_flags(0)) begin
      errors++; $display("FAIL b2b_empty: got %b want %b", flags(), exp_flags(0));
    end
  endtask

  task automatic test_corner();
    for (int i = 0; i < 16; i++) wr(8'(8'h30 + i));
    bus.wren = 1'b1; bus.wrdata = 8'hAA; bus.rden = 1'b1;
    tick();
    bus.wren = 1'b0; bus.rden = 1'b0;
    checks++;
    if (bus.rddata !== 8'h30 || flags() !== exp_flags(15)) begin
      errors++; $display("FAIL full_wr_rd: got %h/%b want 30/%b", bus.rddata, flags(), exp_flags(15));
    end
    for (int i = 1; i < 16; i++) begin
      rd();
      checks++;
      if (bus.rddata !== 8'(8'h30 + i)) begin
        errors++; $display("FAIL full_drain[%0d]: got %h want %h", i, bus.rddata, 8'(8'h30 + i));
      end
    end
    checks++;
    if (flags() !== exp_flags(0)) begin
      errors++; $display("FAIL full_drain_empty: got %b want %b", flags(), exp_flags(0));
    end
    bus.wren = 1'b1; bus.wrdata = 8'h55; bus.rden = 1'b1;
    tick();
    bus.wren = 1'b0; bus.rden = 1'b0;
    checks++;
    if (bus.rddata !== 8'h3F || flags() !== exp_flags(1)) begin
      errors++; $display("FAIL empty_wr_rd: got %h/%b want 3f/%b", bus.rddata, flags(), exp_flags(1));
    end
    rd();
    checks++;
    if (bus.rddata !== 8'h55 || flags() !== exp_flags(0)) begin
      errors++; $display("FAIL empty_wr_rd_data: got %h/%b want 55/%b", bus.rddata, flags(), exp_flags(0));
    end
  endtask

`ifdef FIFO_ERR_EN
  task automatic test_err();
    rstn = 1'b0; #1 rstn = 1'b1;
    tick();
    checks++;
    if ({bus.overflow, bus.underflow} !== 2'b00) begin
      errors++; $display("FAIL err_reset: got %b want 00", {bus.overflow, bus.underflow});
    end
    rd(); tick();
    checks++;
    if ({bus.overflow, bus.underflow} !== 2'b01) begin
      errors++; $display("FAIL err_underflow: got %b want 01", {bus.overflow, bus.underflow});
    end
    for (int i = 0; i < 16; i++) wr(8'(i));
    checks++;
    if ({bus.overflow, bus.underflow} !== 2'b01) begin
      errors++; $display("FAIL err_full_no_ovf: got %b want 01", {bus.overflow, bus.underflow});
    end
    wr(8'hEE); tick();
    checks++;
    if ({bus.overflow, bus.underflow} !== 2'b11) begin
      errors++; $display("FAIL err_overflow: got %b want 11", {bus.overflow, bus.underflow});
    end
    rstn = 1'b0; #1;
    checks++;
    if ({bus.overflow, bus.underflow} !== 2'b00) begin
      errors++; $display("FAIL err_clear: got %b want 00", {bus.overflow, bus.underflow});
    end
    rstn = 1'b1;
    tick();
  endtask
`endif

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_fill_drain();
    test_reset_mid();
    test_alm_empty();
    test_back_to_back();
    test_corner();
`ifdef FIFO_ERR_EN
    test_err();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/modport_fifo.md
Name: modport_fifo

Overview:
- Single-clock synchronous FIFO with full/empty and programmable almost-full/almost-empty status flags.
- Sits between a producer and a consumer in the same clock domain.
- Connects through the fifo_intf bundle: the driver side drives write/read strobes and write data; the monitor sides sample read data and flags.

Parameters:
- DATA_W, 8, width of each data word.
- DEPTH, 16, number of storage entries; power of two, minimum 4.
- ALM_FULL_TH, 14, o_alm_full asserted when occupancy >= this value; range 1..DEPTH-1.
- ALM_EMPTY_TH, 2, o_alm_empty asserted when occupancy <= this value; range 1..DEPTH-1.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rstn  input  1  asynchronous active-low reset.
- i_wren  input  1  write request.
- i_wrdata  input  DATA_W  write data, sampled with i_wren.
- i_rden  input  1  read request.
- o_rddata  output  DATA_W  registered read data.
- o_full  output  1  occupancy == DEPTH.
- o_empty  output  1  occupancy == 0.
- o_alm_full  output  1  occupancy >= ALM_FULL_TH.
- o_alm_empty  output  1  occupancy <= ALM_EMPTY_TH.

Behaviour:
- Internal state: write pointer and read pointer, each $clog2(DEPTH) bits, wrapping modulo DEPTH; occupancy counter, $clog2(DEPTH)+1 bits.
- Reset (rstn low, asynchronous): pointers = 0, count = 0, o_rddata = 0. Flags: o_empty = 1, o_alm_empty = 1, o_full = 0, o_alm_full = 0. Storage contents are not reset.
- Write accepted at a rising edge iff i_wren && !o_full. The word is stored at the write pointer, and the write pointer increments.
- Read accepted at a rising edge iff i_rden && !o_empty. o_rddata loads the word at the read pointer at that edge, so data is valid the cycle after the request. The read pointer increments.
- o_rddata holds its value when no read is accepted.
- Acceptance is judged on the flags before the edge.
  - Full with simultaneous wr+rd: read accepted, write dropped; count goes to DEPTH-1.
  - Empty with simultaneous wr+rd: write accepted, read ignored; count goes to 1 and o_rddata is unchanged. There is no fall-through.
  - Otherwise both accepted, count unchanged, and data order is preserved.
- Write to a full FIFO is dropped silently; read from an empty FIFO is ignored silently. Neither changes any state.
- Count update: +1 write only, -1 read only, 0 for both or neither.
- All four flags are combinational decodes of the registered count, so they change in the cycle after the causing edge.
- Pointer wrap: after DEPTH writes the write pointer returns to 0. The count distinguishes full from empty when the pointers are equal.
- Reset asserted mid-operation discards all contents immediately; the FIFO is empty on deassertion.

Optional Feature:
- Macro FIFO_ERR_EN adds two outputs, o_overflow and o_underflow, each 1 bit.
  - o_overflow sets on a rising edge where i_wren && o_full.
  - o_underflow sets on a rising edge where i_rden && o_empty.
  - Both flags are sticky until rstn; reset value is 0.
- Without the macro these ports and their logic are absent, and behaviour is otherwise identical.

Decomposition:
- Package fifo_pkg holds the default DATA_W, DEPTH and threshold constants, plus the pointer/count width helper localparams, so fifo_intf and the FIFO share one source.
- One sub-module, fifo_mem: a simple dual-port register array (DEPTH x DATA_W) with synchronous write and registered read, instantiated once.

Test Plan:
- Reset: assert rstn low mid-traffic -> o_empty=1, o_alm_empty=1, o_full=0, o_alm_full=0, o_rddata=0; a later read returns nothing old.
- Fill/drain: write 0x01..0x10 (16 words) -> o_alm_full rises after the 14th, o_full after the 16th; 17th write (0xFF) dropped; then 16 reads return 0x01..0x10 in order, each one cycle after i_rden, and o_empty=1 after the last.
- Almost-empty boundary: write 3 words -> o_alm_empty=1 at counts 1 and 2, 0 at count 3; read 1 -> o_alm_empty=1 again.
- Simultaneous wr+rd at count 5 (continuous for 40 cycles) -> count stays 5, flags stable, data order preserved across pointer wrap.
- Corner simultaneous: at full, wr 0xAA + rd -> count 15, 0xAA not stored; at empty, wr 0x55 + rd -> count 1, o_rddata unchanged, next read returns 0x55.
- FIFO_ERR_EN: read when empty -> o_underflow=1 and held; write when full -> o_overflow=1; both clear only on rstn.
